// File: rtl/xadac_vbias_pipe_if.sv
// rtl/xadac_vbias_pipe_if.sv - xadac channel types and dispatcher/slave interface
package xadac_pkg;

  localparam int unsigned InstrWidth   = 32;
  localparam int unsigned IdWidth      = 8;
  localparam int unsigned RegAddrWidth = 5;
  localparam int unsigned RegDataWidth = 32;
  localparam int unsigned VecDataWidth = 128;
  localparam int unsigned VecSumWidth  = 16;
  localparam int unsigned VecLenWidth  = 4;
  localparam int unsigned NumRs        = 2;
  localparam int unsigned NumVs        = 3;

  typedef struct packed {
    logic [IdWidth-1:0]    id;
    logic [InstrWidth-1:0] instr;
  } dec_req_t;

  typedef struct packed {
    logic [IdWidth-1:0] id;
    logic               rd_clobber;
    logic               vd_clobber;
    logic [NumRs-1:0]   rs_read;
    logic [NumVs-1:0]   vs_read;
    logic               accept;
  } dec_rsp_t;

  typedef struct packed {
    logic [IdWidth-1:0]                    id;
    logic [InstrWidth-1:0]                 instr;
    logic [NumRs-1:0][RegDataWidth-1:0]    rs_data;
    logic [NumVs-1:0][VecDataWidth-1:0]    vs_data;
  } exe_req_t;

  typedef struct packed {
    logic [IdWidth-1:0]      id;
    logic [RegAddrWidth-1:0] rd_addr;
    logic [RegDataWidth-1:0] rd_data;
    logic                    rd_write;
    logic [RegAddrWidth-1:0] vd_addr;
    logic [VecDataWidth-1:0] vd_data;
    logic                    vd_write;
  } exe_rsp_t;

endpackage

// Decode and execute handshake channels between dispatcher (mst) and unit (slv)
interface xadac_if;
  import xadac_pkg::*;

  logic     dec_req_valid;
  logic     dec_req_ready;
  dec_req_t dec_req;
  logic     dec_rsp_valid;
  logic     dec_rsp_ready;
  dec_rsp_t dec_rsp;

  logic     exe_req_valid;
  logic     exe_req_ready;
  exe_req_t exe_req;
  logic     exe_rsp_valid;
  logic     exe_rsp_ready;
  exe_rsp_t exe_rsp;

  modport slv (
    input  dec_req_valid, dec_req, dec_rsp_ready,
    input  exe_req_valid, exe_req, exe_rsp_ready,
    output dec_req_ready, dec_rsp_valid, dec_rsp,
    output exe_req_ready, exe_rsp_valid, exe_rsp
  );

  modport mst (
    output dec_req_valid, dec_req, dec_rsp_ready,
    output exe_req_valid, exe_req, exe_rsp_ready,
    input  dec_req_ready, dec_rsp_valid, dec_rsp,
    input  exe_req_ready, exe_rsp_valid, exe_rsp
  );

endinterface

// File: rtl/xadac_vbias_pipe.sv
// rtl/xadac_vbias_pipe.sv - pipelined vector bias splat/add/saturating-add xadac slave
module xadac_vbias_pipe
  import xadac_pkg::*;
#(
  parameter int unsigned NumLanes  = 8,
  parameter int unsigned LaneWidth = VecSumWidth,
  // Execute pipeline depth, 1..4.
  parameter int unsigned Stages    = 2,
  parameter bit          SatEnable = 1'b1
) (
  input  logic                          clk,
  input  logic                          rstn,
  xadac_if.slv                          slv,
  output logic [$clog2(Stages+1)-1:0]   inflight
);

  localparam int unsigned InflW = $clog2(Stages + 1);

  localparam logic [2:0] ModeSplat = 3'b000;
  localparam logic [2:0] ModeAdd   = 3'b001;
  localparam logic [2:0] ModeSat   = 3'b010;

  localparam logic [LaneWidth-1:0] SatMax = {1'b0, {(LaneWidth-1){1'b1}}};
  localparam logic [LaneWidth-1:0] SatMin = {1'b1, {(LaneWidth-1){1'b0}}};

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  logic [2:0] dec_mode;
  assign dec_mode = slv.dec_req.instr[14:12];

  // Decode is a pure function of the request; no state is kept
  always_comb begin
    slv.dec_rsp_valid          = slv.dec_req_valid;
    slv.dec_req_ready          = slv.dec_req_valid && slv.dec_rsp_ready;
    slv.dec_rsp                = '0;
    slv.dec_rsp.id             = slv.dec_req.id;
    slv.dec_rsp.rd_clobber     = 1'b0;
    slv.dec_rsp.vd_clobber     = 1'b1;
    slv.dec_rsp.rs_read        = NumRs'(1);
    slv.dec_rsp.vs_read        = '0;
    slv.dec_rsp.vs_read[0]     = (dec_mode != ModeSplat);
    case (dec_mode)
      ModeSplat: slv.dec_rsp.accept = 1'b1;
      ModeAdd:   slv.dec_rsp.accept = 1'b1;
      ModeSat:   slv.dec_rsp.accept = SatEnable;
      default:   slv.dec_rsp.accept = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Execute: lane arithmetic, evaluated on the incoming request
  // ---------------------------------------------------------------------------
  logic [2:0]              exe_mode;
  logic [VecLenWidth-1:0]  exe_vlen;
  logic [LaneWidth-1:0]    bias;
  logic [VecDataWidth-1:0] lane_res;
  logic [LaneWidth-1:0]    lane_a;
  logic [LaneWidth-1:0]    lane_r;
  logic [LaneWidth:0]      lane_s;

  assign exe_mode = slv.exe_req.instr[14:12];
  assign exe_vlen = slv.exe_req.instr[25 +: VecLenWidth];
  assign bias     = slv.exe_req.rs_data[0][LaneWidth-1:0];

  // Per-lane result; lanes at or beyond vlen, and bits above the lane field, stay zero
  always_comb begin
    lane_res = '0;
    lane_a   = '0;
    lane_r   = '0;
    lane_s   = '0;
    for (int i = 0; i < int'(NumLanes); i++) begin
      lane_a = slv.exe_req.vs_data[0][LaneWidth*i +: LaneWidth];
      // One extra bit of sign-extended sum exposes signed overflow
      lane_s = {lane_a[LaneWidth-1], lane_a} + {bias[LaneWidth-1], bias};
      case (exe_mode)
        ModeSplat: lane_r = bias;
        ModeAdd:   lane_r = lane_a + bias;
        ModeSat: begin
          if (!SatEnable) begin
            lane_r = '0;
          end else if (lane_s[LaneWidth] != lane_s[LaneWidth-1]) begin
            lane_r = lane_s[LaneWidth] ? SatMin : SatMax;
          end else begin
            lane_r = lane_s[LaneWidth-1:0];
          end
        end
        default:   lane_r = '0;
      endcase
      if (i < int'(exe_vlen)) begin
        lane_res[LaneWidth*i +: LaneWidth] = lane_r;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Execute: elastic pipeline
  // ---------------------------------------------------------------------------
  logic [Stages-1:0]                        v_q, v_d;
  logic [Stages-1:0]                        adv;
  logic [Stages-1:0][IdWidth-1:0]           id_q, id_d;
  logic [Stages-1:0][RegAddrWidth-1:0]      addr_q, addr_d;
  logic [Stages-1:0][VecDataWidth-1:0]      data_q, data_d;
  logic                                     req_ready;
  logic                                     push;
  logic                                     hole;

  // A valid stage moves on when the sink is ready or any later stage is empty,
  // which is the unrolled form of "next stage empty or advancing"
  always_comb begin
    adv  = '0;
    hole = 1'b0;
    for (int k = 0; k < int'(Stages); k++) begin
      hole = slv.exe_rsp_ready;
      for (int j = k + 1; j < int'(Stages); j++) begin
        if (!v_q[j]) begin
          hole = 1'b1;
        end
      end
      adv[k] = v_q[k] && hole;
    end
  end

  assign req_ready         = !v_q[0] || adv[0];
  assign push              = slv.exe_req_valid && req_ready;
  assign slv.exe_req_ready = req_ready;

  // Next-state for every stage: stage 0 loads new requests, later stages load their predecessor
  always_comb begin
    v_d    = v_q;
    id_d   = id_q;
    addr_d = addr_q;
    data_d = data_q;
    if (req_ready) begin
      v_d[0] = push;
      if (push) begin
        id_d[0]   = slv.exe_req.id;
        addr_d[0] = slv.exe_req.instr[11:7];
        data_d[0] = lane_res;
      end
    end
    for (int k = 1; k < int'(Stages); k++) begin
      if (!v_q[k] || adv[k]) begin
        v_d[k] = adv[k-1];
        if (adv[k-1]) begin
          id_d[k]   = id_q[k-1];
          addr_d[k] = addr_q[k-1];
          data_d[k] = data_q[k-1];
        end
      end
    end
  end

  // Stage registers; reset discards everything in flight
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v_q    <= '0;
      id_q   <= '0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      v_q    <= v_d;
      id_q   <= id_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  // Response is the last stage; vd_write follows valid so the bus reads zero when idle after reset
  always_comb begin
    slv.exe_rsp_valid    = v_q[Stages-1];
    slv.exe_rsp          = '0;
    slv.exe_rsp.id       = id_q[Stages-1];
    slv.exe_rsp.vd_addr  = addr_q[Stages-1];
    slv.exe_rsp.vd_data  = data_q[Stages-1];
    slv.exe_rsp.vd_write = v_q[Stages-1];
  end

  // Occupancy count of the pipeline
  always_comb begin
    inflight = '0;
    for (int k = 0; k < int'(Stages); k++) begin
      inflight = inflight + InflW'(v_q[k]);
    end
  end

  // Request fields outside the decoded bit ranges are intentionally ignored
  logic unused_ok;
  assign unused_ok = ^{slv.dec_req, slv.exe_req};

endmodule
